// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the I/D memory arbiter.
// Ownership state encoding and owner identifiers.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_D = 2'd1,
    OWN_I = 2'd2
  } arbState_t;

  localparam logic OWNER_D = 1'b0;
  localparam logic OWNER_I = 1'b1;

endpackage

// File: rtl/mem_arb_outstanding.sv
// mem_arb_outstanding: in-flight read counter for the memory arbiter.
// Accepts returns only when reads are pending; flags over/underflow.
module mem_arb_outstanding #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         ret,
  output logic         accept,
  output logic         overflow,
  output logic         underflow,
  output logic [W-1:0] countNext
);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] count;

  assign accept    = ret && (count != '0);
  assign underflow = ret && (count == '0);
  assign overflow  = inc && (count == MAXV);

  always_comb begin
    countNext = count;
    if (inc && !accept && !overflow)
      countNext = count + 1'b1;
    else if (accept && !inc)
      countNext = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else      count <= countNext;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multicycle memory between the I- and D-cache
// miss handlers; a grant is held until the owner's fill fully drains.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_write,
  input  logic              d_busy,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wait,
  output logic              d_valid,
  input  logic              i_req,
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_wait,
  output logic              i_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              err
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_V = CNT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_V = STV_W'(STARVE_MAX);

  arbState_t        state, stateNext;
  logic [STV_W-1:0] starve, starveNext;
  logic [CNT_W-1:0] maskCnt, outNext;
  logic dAct, iAct, winner, grantD, grantI;
  logic ret, issueRd, accept, ovf, unf;

  assign dAct    = d_req | d_busy;
  assign iAct    = i_req | i_busy;
  assign rdata   = mem_rdata;
  // Returns are ignored until MEM_LAT cycles after reset release.
  assign ret     = mem_valid && (maskCnt == LAT_V);
  assign issueRd = mem_enable & ~mem_write;

  mem_arb_outstanding #(.MAX(MEM_LAT), .W(CNT_W)) uOut (
    .clk       (clk),
    .rst       (rst),
    .inc       (issueRd),
    .ret       (ret),
    .accept    (accept),
    .overflow  (ovf),
    .underflow (unf),
    .countNext (outNext)
  );

  always_comb begin
    winner = OWNER_D;
    if (iAct && (!dAct || starve >= STV_V))
      winner = OWNER_I;
    grantD = 1'b0;
    grantI = 1'b0;
    stateNext = state;
    unique case (1'b1)
      (state == IDLE): begin
        grantD = dAct && (winner == OWNER_D);
        grantI = iAct && (winner == OWNER_I);
        if (grantD)      stateNext = OWN_D;
        else if (grantI) stateNext = OWN_I;
      end
      (state == OWN_D): begin
        grantD = 1'b1;
        if (!d_busy && !d_req && outNext == '0)
          stateNext = IDLE;
      end
      (state == OWN_I): begin
        grantI = 1'b1;
        if (!i_busy && !i_req && outNext == '0)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    starveNext = starve;
    if (stateNext == OWN_I && state != OWN_I)
      starveNext = '0;
    else if (iAct && !grantI && starve != STV_V)
      starveNext = starve + 1'b1;
  end

  always_comb begin
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (grantD) begin
      mem_enable = d_req;
      mem_write  = d_req & d_write;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end else if (grantI) begin
      mem_enable = i_req;
      mem_addr   = i_addr;
    end
    d_wait  = d_req & ~grantD;
    i_wait  = i_req & ~grantI;
    d_valid = accept && (state == OWN_D);
    i_valid = accept && (state == OWN_I);
    // Outputs stay quiet while reset is held.
    if (!rst) begin
      mem_enable = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      d_wait     = 1'b0;
      i_wait     = 1'b0;
      d_valid    = 1'b0;
      i_valid    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      starve  <= '0;
      maskCnt <= '0;
      err     <= 1'b0;
    end else begin
      state  <= stateNext;
      starve <= starveNext;
      err    <= err | ovf | unf;
      if (maskCnt != LAT_V)
        maskCnt <= maskCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 4-cycle
// pipelined memory model and hand-computed expectations.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        d_req, d_write, d_busy;
  logic [15:0] d_addr, d_wdata;
  logic        d_wait, d_valid;
  logic        i_req, i_busy;
  logic [15:0] i_addr;
  logic        i_wait, i_valid;
  logic [15:0] rdata;
  logic        mem_enable, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid;
  logic        err;
  logic        stray;

  int checks = 0;
  int errors = 0;
  int nv, ri;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } ret_t;

  ret_t pipe [4] = '{default: '0};

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .d_req      (d_req),
    .d_write    (d_write),
    .d_busy     (d_busy),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wait     (d_wait),
    .d_valid    (d_valid),
    .i_req      (i_req),
    .i_busy     (i_busy),
    .i_addr     (i_addr),
    .i_wait     (i_wait),
    .i_valid    (i_valid),
    .rdata      (rdata),
    .mem_enable (mem_enable),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Read issued in cycle c returns in cycle c+4; data = addr ^ A5A5.
  always @(posedge clk) begin
    pipe[0] <= '{v: mem_enable && !mem_write, d: mem_addr ^ 16'hA5A5};
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end

  assign mem_valid = pipe[3].v | stray;
  assign mem_rdata = pipe[3].d;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0; rst = 0; stray = 0;
    d_req = 1; d_write = 0; d_busy = 0;
    d_addr = 16'h1111; d_wdata = 0;
    i_req = 1; i_busy = 0; i_addr = 16'h7777;

    // Reset: outputs forced low despite active requests
    @(negedge clk); #1;
    check("rst_en", mem_enable, 0);
    check("rst_dwait", d_wait, 0);
    check("rst_iwait", i_wait, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_err", err, 0);

    // Release with stray valids inside the 4-cycle mask
    @(negedge clk);
    rst = 1; d_req = 0; i_req = 0; stray = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("mask_dval", d_valid, 0);
      check("mask_ival", i_valid, 0);
      @(negedge clk);
    end
    stray = 0; #1;
    check("mask_err", err, 0);
    @(negedge clk);

    // 1: D alone, 8 reads, one bubble to stay within MEM_LAT
    nv = 0; ri = 0;
    for (int k = 0; k < 14; k++) begin
      d_busy = (k < 12);
      d_req  = (k < 4) || (k >= 5 && k <= 8);
      d_addr = 16'h1230 + 16'(2 * ri);
      #1;
      if (d_req) begin
        check("d1_en", mem_enable, 1);
        check("d1_addr", mem_addr, 32'h1230 + 2 * ri);
        check("d1_dwait", d_wait, 0);
        ri++;
      end
      check("d1_dval", d_valid, (k >= 4 && k <= 7) || (k >= 9 && k <= 12));
      check("d1_ival", i_valid, 0);
      if (mem_valid) begin
        check("d1_data", rdata, (32'h1230 + 2 * nv) ^ 32'hA5A5);
        nv++;
      end
      @(negedge clk);
    end
    check("d1_nvalid", nv, 8);
    check("d1_err", err, 0);

    // 2: simultaneous requests, D owns, I granted after release
    for (int k = 0; k < 13; k++) begin
      d_busy = (k < 6);
      d_req  = (k < 3);
      d_addr = 16'h1300 + 16'(2 * k);
      i_busy = (k < 11);
      i_req  = (k <= 7);
      i_addr = 16'h2100;
      #1;
      if (k < 7) check("d2_iwait", i_wait, 1);
      if (k < 3) check("d2_daddr", mem_addr, 32'h1300 + 2 * k);
      check("d2_dval", d_valid, (k >= 4 && k <= 6));
      check("d2_ival", i_valid, (k == 11));
      if (k == 7) begin
        check("d2_igrant", i_wait, 0);
        check("d2_ien", mem_enable, 1);
        check("d2_iaddr", mem_addr, 16'h2100);
      end
      if (k == 11) check("d2_idata", rdata, 16'h2100 ^ 16'hA5A5);
      @(negedge clk);
    end

    // 3: starvation lets I outrank D, then starve clears
    d_addr = 16'h5000; i_addr = 16'h6000;
    for (int k = 0; k < 22; k++) begin
      d_busy = (k != 17) && (k <= 20);
      d_req  = (k == 18) || (k == 19);
      i_busy = (k <= 18) || (k == 20);
      i_req  = (k <= 17) || (k == 20);
      #1;
      if (k <= 16) begin
        check("s3_iwait", i_wait, 1);
        check("s3_daddr", mem_addr, 16'h5000);
      end
      if (k == 18) begin
        check("s3_dlose", d_wait, 1);
        check("s3_iwin", mem_addr, 16'h6000);
      end
      if (k == 19) check("s3_dhold", d_wait, 1);
      if (k == 20) begin
        check("s3_clr_iwait", i_wait, 1);
        check("s3_clr_daddr", mem_addr, 16'h5000);
      end
      @(negedge clk);
    end

    // 4: D write held off during I fill, then single-cycle write
    d_busy = 0;
    for (int k = 0; k < 11; k++) begin
      i_busy  = (k < 6) || (k == 9);
      i_req   = (k < 3);
      i_addr  = (k == 9) ? 16'h3000 : 16'h2000 + 16'(2 * k);
      d_req   = (k >= 1 && k <= 7);
      d_write = d_req;
      d_addr  = 16'h0040;
      d_wdata = 16'hBEEF;
      #1;
      if (k < 3) check("w4_iaddr", mem_addr, 32'h2000 + 2 * k);
      if (k >= 1 && k <= 6) begin
        check("w4_dwait", d_wait, 1);
        check("w4_nowr", mem_write, 0);
      end
      check("w4_ival", i_valid, (k >= 4 && k <= 6));
      check("w4_dval", d_valid, 0);
      if (k == 7) begin
        check("w4_dgo", d_wait, 0);
        check("w4_wr", mem_write, 1);
        check("w4_en", mem_enable, 1);
        check("w4_addr", mem_addr, 16'h0040);
        check("w4_data", mem_wdata, 16'hBEEF);
      end
      if (k == 9) check("w4_idle", mem_addr, 16'h3000);
      @(negedge clk);
    end
    check("w4_err", err, 0);

    // 5: stray valid in IDLE is dropped and sets sticky err
    stray = 1; #1;
    check("s5_dval", d_valid, 0);
    check("s5_ival", i_valid, 0);
    @(negedge clk);
    stray = 0; #1;
    check("s5_err", err, 1);
    @(negedge clk); #1;
    check("s5_sticky", err, 1);
    @(negedge clk);

    // 6: reset mid-fill, late valids masked
    for (int k = 0; k < 11; k++) begin
      rst    = (k != 2);
      d_busy = (k <= 2);
      d_req  = (k <= 2);
      d_addr = 16'h4000 + 16'(2 * k);
      i_busy = (k == 9);
      i_req  = 0;
      i_addr = 16'h6100;
      #1;
      if (k == 2) begin
        check("r6_en", mem_enable, 0);
        check("r6_addr", mem_addr, 0);
        check("r6_err", err, 0);
      end
      if (k >= 2) begin
        check("r6_dval", d_valid, 0);
        check("r6_ival", i_valid, 0);
      end
      if (k == 8) check("r6_mask_err", err, 0);
      if (k == 9) check("r6_idle", mem_addr, 16'h6100);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
